mem_bus_arbiter: RTL and testbench

Shares the single external memory bus between the IF-stage instruction fetch port (rom_*) and the MEM-stage data port (ram_*). It arbitrates the two ports, runs a multi-cycle handshake on the bus, returns read data with one-cycle ready pulses, and raises a stall request to the pipeline controller while either port waits. It sits between the PC/MEM stages and the memory interface.

---
 rtl/mem_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares one external memory bus between the instruction-fetch port (rom_*)
// and the data port (ram_*). An idle arbiter grants one port, holds the bus
// request stable until the memory answers, and returns the read word with a
// one-cycle ready pulse. A stall request is raised while either port waits.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   rom_en, rom_addr    : fetch request, held until inst_ready
//   inst_data           : fetched word, valid with inst_ready
//   inst_ready          : one-cycle fetch completion pulse
//   flush               : cancels the instruction side only
//   ram_en, ram_write_en, ram_addr, ram_write_data
//                       : data request (write_en = byte enables, 0 = read)
//   ram_read_data       : load data, valid with ram_ready
//   ram_ready           : one-cycle data completion pulse
//   bus_en, bus_write_en, bus_addr, bus_write_data
//                       : registered bus request, constant during an access
//   bus_read_data, bus_ready
//                       : memory response, sampled only while bus_en=1
//   stall_req           : combinational stall request to the pipeline

`timescale 1ns/1ps

module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_ready,
  input  logic                  flush,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  ram_ready,
  output logic                  bus_en,
  output logic [SEL_WIDTH-1:0]  bus_write_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_ready,
  output logic                  stall_req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IBUSY = 2'd1,
    S_DBUSY = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_last_grant;   // 0 = inst, 1 = data
  logic                  r_discard;      // current fetch was flushed
  logic                  r_resp_port;    // port being answered in RESP

  logic                  r_bus_en;
  logic [SEL_WIDTH-1:0]  r_bus_write_en;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_write_data;
  logic [DATA_WIDTH-1:0] r_inst_data;
  logic [DATA_WIDTH-1:0] r_ram_read_data;
  logic                  r_inst_ready;
  logic                  r_ram_ready;

  logic                  w_inst_ok;
  logic                  w_drop;
  logic                  w_grant_d;
  logic                  w_grant_i;

  // A flush in IDLE blocks the fetch grant for that cycle only.
  assign w_inst_ok = rom_en & ~flush;
  // A flush arriving together with bus_ready still drops the fetch.
  assign w_drop    = r_discard | flush;

  // ---------------------------------------------------------------------
  // Next-state and grant decision
  // ---------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data wins a tie unless it won the previous grant, which makes
        // continuous requests from both ports alternate.
        if (ram_en && (!w_inst_ok || !r_last_grant)) begin
          w_grant_d = 1'b1;
          w_next    = S_DBUSY;
        end else if (w_inst_ok) begin
          w_grant_i = 1'b1;
          w_next    = S_IBUSY;
        end
      end
      S_IBUSY: begin
        if (bus_ready) begin
          w_next = w_drop ? S_IDLE : S_RESP;
        end
      end
      S_DBUSY: begin
        if (bus_ready) begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, bus request and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_last_grant     <= 1'b0;
      r_discard        <= 1'b0;
      r_resp_port      <= 1'b0;
      r_bus_en         <= 1'b0;
      r_bus_write_en   <= '0;
      r_bus_addr       <= '0;
      r_bus_write_data <= '0;
      r_inst_data      <= '0;
      r_ram_read_data  <= '0;
      r_inst_ready     <= 1'b0;
      r_ram_ready      <= 1'b0;
    end else begin
      r_state      <= w_next;
      // Ready flags live only for the single RESP cycle.
      r_inst_ready <= 1'b0;
      r_ram_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_bus_en         <= 1'b1;
            r_bus_write_en   <= ram_write_en;
            r_bus_addr       <= ram_addr;
            r_bus_write_data <= ram_write_data;
            r_last_grant     <= 1'b1;
            r_resp_port      <= 1'b1;
          end else if (w_grant_i) begin
            r_bus_en         <= 1'b1;
            r_bus_write_en   <= '0;
            r_bus_addr       <= rom_addr;
            r_bus_write_data <= '0;
            r_last_grant     <= 1'b0;
            r_resp_port      <= 1'b0;
          end
        end
        S_IBUSY: begin
          if (flush) begin
            r_discard <= 1'b1;
          end
          if (bus_ready) begin
            r_bus_en     <= 1'b0;
            r_inst_data  <= bus_read_data;
            r_inst_ready <= ~w_drop;
            r_discard    <= 1'b0;
          end
        end
        S_DBUSY: begin
          if (bus_ready) begin
            r_bus_en        <= 1'b0;
            r_ram_read_data <= bus_read_data;
            r_ram_ready     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_en         = r_bus_en;
  assign bus_write_en   = r_bus_write_en;
  assign bus_addr       = r_bus_addr;
  assign bus_write_data = r_bus_write_data;
  assign inst_data      = r_inst_data;
  assign ram_read_data  = r_ram_read_data;
  assign ram_ready      = r_ram_ready;

  // A flush during the fetch response cycle suppresses the pulse.
  assign inst_ready = r_inst_ready &
                      ~(flush & (r_state == S_RESP) & ~r_resp_port);

  assign stall_req  = (rom_en & ~inst_ready) | (ram_en & ~ram_ready);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] inst_data;
  logic          inst_ready;
  logic          flush;
  logic          ram_en;
  logic [SW-1:0] ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] ram_read_data;
  logic          ram_ready;
  logic          bus_en;
  logic [SW-1:0] bus_write_en;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_write_data;
  logic [DW-1:0] bus_read_data;
  logic          bus_ready;
  logic          stall_req;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .rom_en(rom_en), .rom_addr(rom_addr), .inst_data(inst_data),
    .inst_ready(inst_ready), .flush(flush),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .ram_ready(ram_ready),
    .bus_en(bus_en), .bus_write_en(bus_write_en), .bus_addr(bus_addr),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_ready(bus_ready), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- memory slave ----------------
  bit        slave_rand = 0;
  int        slave_wait = 0;
  logic [DW-1:0] slave_data = 32'h2402_0005;
  int        s_cnt;

  initial begin
    s_cnt = -1;
    bus_ready = 1'b0;
    bus_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_en) begin
        if (s_cnt < 0) s_cnt = slave_rand ? int'($urandom_range(0, 3)) : slave_wait;
        if (s_cnt == 0) begin
          bus_ready = 1'b1;
          bus_read_data = slave_rand ? $urandom : slave_data;
          s_cnt = -1;
        end else begin
          bus_ready = 1'b0;
          s_cnt--;
        end
      end else begin
        s_cnt = -1;
        // Noise on bus_ready while the bus is idle must be ignored.
        bus_ready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_read_data = $urandom;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit            m_ok = 0;
  bit            m_busy, m_port, m_drop, m_resp, m_last, m_rd;
  bit            m_bus_en, m_irdy, m_rrdy;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_we;
  logic [DW-1:0] m_wd, m_idata, m_rdata;
  bit            seen_i = 0, seen_r = 0;
  int            wait_i = 0, wait_r = 0;

  task automatic model_step();
    bit inst_ok;
    if (!rst) begin
      m_ok = 1; m_busy = 0; m_port = 0; m_drop = 0; m_resp = 0; m_last = 0;
      m_rd = 0; m_bus_en = 0; m_irdy = 0; m_rrdy = 0;
      m_addr = '0; m_we = '0; m_wd = '0; m_idata = '0; m_rdata = '0;
    end else begin
      m_irdy = 0;
      m_rrdy = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (!m_busy) begin
        inst_ok = rom_en && !flush;
        if (ram_en && (!inst_ok || !m_last)) begin
          m_busy = 1; m_port = 1; m_last = 1; m_bus_en = 1;
          m_addr = ram_addr; m_we = ram_write_en; m_wd = ram_write_data;
          m_rd = (ram_write_en == '0);
        end else if (inst_ok) begin
          m_busy = 1; m_port = 0; m_last = 0; m_bus_en = 1;
          m_addr = rom_addr; m_we = '0; m_wd = '0;
        end
      end else begin
        if (!m_port && flush) m_drop = 1;
        if (bus_ready) begin
          m_bus_en = 0;
          m_busy = 0;
          if (m_port) begin
            m_rdata = bus_read_data; m_rrdy = 1; m_resp = 1;
          end else begin
            m_idata = bus_read_data;
            if (!m_drop) begin m_irdy = 1; m_resp = 1; end
          end
          m_drop = 0;
        end
      end
    end
  endtask

  // Compare process: checks every cycle once the model has seen a reset.
  initial begin
    bit e_irdy, e_stall;
    forever begin
      @(negedge clk);
      e_irdy  = m_irdy && !flush;
      e_stall = (rom_en && !e_irdy) || (ram_en && !m_rrdy);
      if (m_ok) begin
        chk("bus_en", bus_en, m_bus_en);
        if (m_bus_en) begin
          chk("bus_addr", bus_addr, m_addr);
          chk("bus_write_en", bus_write_en, m_we);
          if (m_we != '0) chk("bus_write_data", bus_write_data, m_wd);
        end
        chk("inst_ready", inst_ready, e_irdy);
        chk("ram_ready", ram_ready, m_rrdy);
        chk("stall_req", stall_req, e_stall);
        if (e_irdy) chk("inst_data", inst_data, m_idata);
        if (m_rrdy && m_rd) chk("ram_read_data", ram_read_data, m_rdata);
        wait_i = (rst && rom_en && !e_irdy && !flush) ? wait_i + 1 : 0;
        wait_r = (rst && ram_en && !m_rrdy) ? wait_r + 1 : 0;
        if (rom_en) chk("inst_wait_bound", wait_i <= 40, 1);
        if (ram_en) chk("data_wait_bound", wait_r <= 40, 1);
      end
      seen_i = e_irdy;
      seen_r = m_rrdy;
      model_step();
    end
  end

  // ---------------- directed-run recorder ----------------
  bit            en_hist[0:31];
  bit            st_hist[0:31];
  int            qr[$], qi[$];
  bit            gport[$];
  logic [AW-1:0] g_addr[$];
  logic [SW-1:0] g_we[$];
  logic [DW-1:0] g_wd[$];
  logic [DW-1:0] i_dat;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input bit drop, input int flush_at);
    bit prev_en, got_r, got_i;
    qr.delete(); qi.delete(); gport.delete(); g_addr.delete();
    g_we.delete(); g_wd.delete();
    prev_en = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c < 32) begin
        en_hist[c] = bus_en;
        st_hist[c] = stall_req;
      end
      got_r = ram_ready;
      got_i = inst_ready;
      if (got_r) qr.push_back(c);
      if (got_i) begin qi.push_back(c); i_dat = inst_data; end
      if (bus_en && !prev_en) begin
        gport.push_back(bus_addr[13]);
        g_addr.push_back(bus_addr);
        g_we.push_back(bus_write_en);
        g_wd.push_back(bus_write_data);
      end
      prev_en = bus_en;
      tick();
      flush = (c + 1 == flush_at);
      if (flush) rom_addr = rom_addr + 32'h100;
      if (drop && got_r) ram_en = 1'b0;
      if (drop && got_i) rom_en = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rom_en = 0; ram_en = 0; flush = 0;
    repeat (n) tick();
  endtask

  task automatic new_ram();
    ram_en = 1;
    ram_addr = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
    ram_write_en = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
    ram_write_data = $urandom;
  endtask

  task automatic new_rom();
    rom_en = 1;
    rom_addr = 32'h0040_0000 | ($urandom & 32'h0000_FFFC);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bit pf;
    rst = 0; rom_en = 0; rom_addr = '0; flush = 0;
    ram_en = 0; ram_write_en = '0; ram_addr = '0; ram_write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Reset state
    @(negedge clk);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_inst_ready", inst_ready, 0);
    chk("rst_ram_ready", ram_ready, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_stall", stall_req, 0);
    idle(1);

    // Single fetch, one wait state
    slave_wait = 1; slave_data = 32'h2402_0005;
    rom_en = 1; rom_addr = 32'h1000;
    run(5, 1, -1);
    chk("t1_bus_en_c1", en_hist[1], 1);
    chk("t1_bus_addr", g_addr.size() > 0 ? g_addr[0] : 32'hFFFF_FFFF, 32'h1000);
    chk("t1_bus_we", g_we.size() > 0 ? g_we[0] : 4'hA, 0);
    chk("t1_inst_ready_cycle", qi.size() == 1 ? qi[0] : -1, 3);
    chk("t1_inst_data", i_dat, 32'h2402_0005);
    chk("t1_stall_c1", st_hist[1], 1);
    chk("t1_stall_c3", st_hist[3], 0);
    chk("t1_stall_c4", st_hist[4], 0);
    idle(2);

    // Simultaneous store and fetch, zero-wait memory
    slave_wait = 0;
    rom_en = 1; rom_addr = 32'h1004;
    ram_en = 1; ram_addr = 32'h2000; ram_write_en = 4'hF; ram_write_data = 32'hDEAD_BEEF;
    run(8, 1, -1);
    chk("t2_grants", gport.size(), 2);
    chk("t2_first_is_data", gport.size() > 0 ? gport[0] : 0, 1);
    chk("t2_first_we", g_we.size() > 0 ? g_we[0] : 4'h0, 4'hF);
    chk("t2_first_wdata", g_wd.size() > 0 ? g_wd[0] : 32'h0, 32'hDEAD_BEEF);
    chk("t2_first_addr", g_addr.size() > 0 ? g_addr[0] : 32'h0, 32'h2000);
    chk("t2_ram_ready_cycle", qr.size() == 1 ? qr[0] : -1, 2);
    chk("t2_inst_ready_cycle", qi.size() == 1 ? qi[0] : -1, 5);
    idle(2);

    // Both ports held continuously: grants alternate D, I, D, I
    rom_en = 1; rom_addr = 32'h1008;
    ram_en = 1; ram_addr = 32'h2010; ram_write_en = 4'h0;
    run(12, 0, -1);
    rom_en = 0; ram_en = 0;
    chk("t4_grant_count", gport.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_grant_order", k < gport.size() ? gport[k] : 1'bx, (k % 2 == 0) ? 1 : 0);
    chk("t4_ram_ready_count", qr.size(), 2);
    chk("t4_inst_ready_count", qi.size(), 2);
    chk("t4_ram_ready_first", qr.size() > 0 ? qr[0] : -1, 2);
    chk("t4_inst_ready_first", qi.size() > 0 ? qi[0] : -1, 5);
    idle(2);

    // Fetch with 4 wait states, flushed in the 2nd busy cycle
    slave_wait = 4;
    rom_en = 1; rom_addr = 32'h1000;
    run(14, 1, 2);
    for (int c = 1; c <= 5; c++) chk("t3_bus_held", en_hist[c], 1);
    chk("t3_bus_released", en_hist[6], 0);
    chk("t3_regrant", en_hist[7], 1);
    chk("t3_inst_ready_count", qi.size(), 1);
    chk("t3_inst_ready_cycle", qi.size() > 0 ? qi[0] : -1, 12);
    chk("t3_second_addr", g_addr.size() > 1 ? g_addr[1] : 32'h0, 32'h1100);
    idle(2);

    // Reset during a data access
    slave_wait = 3;
    ram_en = 1; ram_addr = 32'h2040; ram_write_en = 4'h0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5_dbusy", bus_en, 1);
    tick();
    rst = 0;
    @(negedge clk);
    tick();
    rst = 1;
    @(negedge clk);
    chk("t5_bus_en", bus_en, 0);
    chk("t5_bus_addr", bus_addr, 0);
    chk("t5_bus_we", bus_write_en, 0);
    chk("t5_bus_wdata", bus_write_data, 0);
    chk("t5_inst_ready", inst_ready, 0);
    chk("t5_ram_ready", ram_ready, 0);
    chk("t5_inst_data", inst_data, 0);
    chk("t5_ram_read_data", ram_read_data, 0);
    run(6, 1, -1);
    chk("t5_restart_grant", gport.size(), 1);
    chk("t5_restart_addr", g_addr.size() > 0 ? g_addr[0] : 32'h0, 32'h2040);
    chk("t5_ram_ready_cycle", qr.size() == 1 ? qr[0] : -1, 4);
    idle(2);

    // Randomized traffic
    slave_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      pf = flush;
      rst = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if (!ram_en) begin
        if ($urandom_range(0, 3) == 0) new_ram();
      end else if (seen_r) begin
        if ($urandom_range(0, 1) == 1) new_ram(); else ram_en = 0;
      end
      if (!rom_en) begin
        if ($urandom_range(0, 2) == 0) new_rom();
      end else if (seen_i || pf) begin
        if ($urandom_range(0, 1) == 1) new_rom(); else rom_en = 0;
      end
    end
    rst = 1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
